cla_subtractor_pipe_13bit: RTL and testbench



---
 rtl/adder_pkg.sv | 22 ++
 rtl/bla_group4.sv | 31 +++
 rtl/cla_subtractor_pipe_13bit.sv | 122 ++++++++++++
 tb/tb_cla_subtractor_pipe_13bit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared widths, vector types and the 4-bit borrow-lookahead group function
// used by the pipelined carry-lookahead subtractor.
package adder_pkg;

  localparam int ADD_WIDTH     = 13;
  localparam int SPLIT_DEFAULT = 7;

  typedef logic [ADD_WIDTH:0]   min_t;
  typedef logic [ADD_WIDTH-1:0] sub_t;
  typedef logic [ADD_WIDTH-1:0] res_t;

  // Returns {gen, prop} for a - b over a 4-bit group.
  function automatic logic [1:0] bla_gp4(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] g;
    logic [3:0] p;
    g = ~a & b;
    p = ~(a ^ b);
    return {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]),
            &p};
  endfunction

endpackage

// File: rtl/bla_group4.sv
// 4-bit borrow-lookahead subtract block: d = a - b - bin, with group
// generate/propagate for the next lookahead level. Purely combinational.
module bla_group4
  import adder_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       bin_i,
  output logic [3:0] d_o,
  output logic       gen_o,
  output logic       prop_o,
  output logic       bout_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] bw;

  assign g = ~a_i & b_i;
  assign p = ~(a_i ^ b_i);

  assign bw[0] = bin_i;
  assign bw[1] = g[0] | (p[0] & bin_i);
  assign bw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin_i);
  assign bw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bin_i);

  assign d_o = a_i ^ b_i ^ bw;
  assign {gen_o, prop_o} = bla_gp4(a_i, b_i);
  assign bout_o = gen_o | (prop_o & bin_i);

endmodule

// File: rtl/cla_subtractor_pipe_13bit.sv
// Two-stage borrow-lookahead subtractor: recovers result = i_min - i_sub,
// flagging o_err when the difference is negative or does not fit WIDTH bits.
module cla_subtractor_pipe_13bit
  import adder_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH,
  parameter int SPLIT = SPLIT_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH:0]   i_min,
  input  logic [WIDTH-1:0] i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_err
);

  localparam int UW  = WIDTH + 1 - SPLIT;
  localparam int NG1 = (SPLIT + 3) / 4;
  localparam int NG2 = (UW + 3) / 4;

  logic             s1_vld_q, s1_vld_d;
  logic             s2_vld_q, s2_vld_d;
  logic [SPLIT-1:0] s1_low_q;
  logic             s1_b_q;
  logic [UW-1:0]    s1_min_q;
  logic [UW-2:0]    s1_sub_q;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic             in_hs, adv2;

  assign adv2     = s1_vld_q & (~s2_vld_q | i_ready);
  assign o_ready  = ~s1_vld_q | adv2;
  assign in_hs    = i_valid & o_ready;
  assign s1_vld_d = in_hs | (s1_vld_q & ~adv2);
  assign s2_vld_d = adv2 | (s2_vld_q & ~i_ready);

  // Stage 1: low SPLIT bits; operands zero-padded to whole groups so padded
  // bits simply pass the borrow through to the stage borrow-out.
  logic [4*NG1-1:0] a1, b1v, d1;
  logic [NG1:0]     c1;
  logic [NG1-1:0]   g1, p1, bo1;

  always_comb begin
    a1  = '0;
    b1v = '0;
    a1[SPLIT-1:0]  = i_min[SPLIT-1:0];
    b1v[SPLIT-1:0] = i_sub[SPLIT-1:0];
  end

  assign c1[0] = 1'b0;
  for (genvar k = 0; k < NG1; k++) begin : g_st1
    bla_group4 u_grp (
      .a_i(a1[4*k +: 4]), .b_i(b1v[4*k +: 4]), .bin_i(c1[k]),
      .d_o(d1[4*k +: 4]), .gen_o(g1[k]), .prop_o(p1[k]), .bout_o(bo1[k])
    );
    assign c1[k+1] = g1[k] | (p1[k] & c1[k]);
  end

  // Stage 2: upper field from the registered operands plus stage-1 borrow.
  logic [4*NG2-1:0] a2, b2v, d2;
  logic [NG2:0]     c2;
  logic [NG2-1:0]   g2, p2, bo2;
  logic [UW-1:0]    upper;

  always_comb begin
    a2  = '0;
    b2v = '0;
    a2[UW-1:0]  = s1_min_q;
    b2v[UW-2:0] = s1_sub_q;
  end

  assign c2[0] = s1_b_q;
  for (genvar k = 0; k < NG2; k++) begin : g_st2
    bla_group4 u_grp (
      .a_i(a2[4*k +: 4]), .b_i(b2v[4*k +: 4]), .bin_i(c2[k]),
      .d_o(d2[4*k +: 4]), .gen_o(g2[k]), .prop_o(p2[k]), .bout_o(bo2[k])
    );
    assign c2[k+1] = g2[k] | (p2[k] & c2[k]);
  end

  assign upper = d2[UW-1:0];
  assign res_d = {upper[UW-2:0], s1_low_q};
  assign err_d = c2[NG2] | upper[UW-1];

  logic unused_bits;
  assign unused_bits = ^{bo1, bo2, d1, d2};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      if (adv2) begin
        res_q <= res_d;
        err_q <= err_d;
      end
    end
  end

  // Payload-only register: no reset, loads only on the input handshake.
  always_ff @(posedge i_clk) begin
    if (in_hs) begin
      s1_low_q <= d1[SPLIT-1:0];
      s1_b_q   <= c1[NG1];
      s1_min_q <= i_min[WIDTH:SPLIT];
      s1_sub_q <= i_sub[WIDTH-1:SPLIT];
    end
  end

  assign o_valid  = s2_vld_q;
  assign o_result = res_q;
  assign o_err    = err_q;

endmodule

// File: tb/tb_cla_subtractor_pipe_13bit.sv
// Directed-vector and random checks of the pipelined 13-bit subtractor.
module tb_cla_subtractor_pipe_13bit;
  import adder_pkg::*;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_valid = 1'b0;
  logic i_ready = 1'b0;
  min_t i_min = '0;
  sub_t i_sub = '0;
  logic o_ready, o_valid, o_err;
  res_t o_result;

  cla_subtractor_pipe_13bit dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_min(i_min), .i_sub(i_sub), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    min_t min;
    sub_t sub;
    res_t res;
    logic err;
  } vec_t;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [13:0] ref_fn(input min_t m, input sub_t s);
    logic [14:0] d;
    d = {1'b0, m} - {2'b00, s};
    return {d[14] | d[13], d[12:0]};
  endfunction

  vec_t vt[12];
  vec_t bp[4];

  initial begin
    vt[0]  = '{14'h2000, 13'h0001, 13'h1FFF, 1'b0};
    vt[1]  = '{14'h3FFE, 13'h1FFF, 13'h1FFF, 1'b0};
    vt[2]  = '{14'h0005, 13'h0006, 13'h1FFF, 1'b1};
    vt[3]  = '{14'h3FFF, 13'h0000, 13'h1FFF, 1'b1};
    vt[4]  = '{14'h0080, 13'h0001, 13'h007F, 1'b0};
    vt[5]  = '{14'h1234, 13'h0234, 13'h1000, 1'b0};
    vt[6]  = '{14'h0000, 13'h0000, 13'h0000, 1'b0};
    vt[7]  = '{14'h2000, 13'h0000, 13'h0000, 1'b1};
    vt[8]  = '{14'h1FFF, 13'h1FFF, 13'h0000, 1'b0};
    vt[9]  = '{14'h0100, 13'h0081, 13'h007F, 1'b0};
    vt[10] = '{14'h0000, 13'h0001, 13'h1FFF, 1'b1};
    vt[11] = '{14'h3FFF, 13'h1FFF, 13'h0000, 1'b1};
    bp[0]  = '{14'h0100, 13'h0001, 13'h00FF, 1'b0};
    bp[1]  = '{14'h1000, 13'h0800, 13'h0800, 1'b0};
    bp[2]  = '{14'h2005, 13'h0005, 13'h0000, 1'b1};
    bp[3]  = '{14'h0003, 13'h0001, 13'h0002, 1'b0};

    // Reset state
    @(negedge i_clk);
    chk("rst o_valid", o_valid, 0);
    chk("rst o_result", o_result, 0);
    chk("rst o_err", o_err, 0);
    i_rst = 1'b0;
    #1 chk("post-rst o_ready", o_ready, 1);

    // Directed table, one beat at a time, checking 2-cycle latency
    i_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge i_clk);
      i_valid = 1'b1; i_min = vt[i].min; i_sub = vt[i].sub;
      #1 chk($sformatf("vec%0d o_ready", i), o_ready, 1);
      @(negedge i_clk);
      i_valid = 1'b0;
      #1 chk($sformatf("vec%0d early o_valid", i), o_valid, 0);
      @(negedge i_clk);
      #1;
      chk($sformatf("vec%0d o_valid", i), o_valid, 1);
      chk($sformatf("vec%0d o_result", i), o_result, vt[i].res);
      chk($sformatf("vec%0d o_err", i), o_err, vt[i].err);
    end

    // Backpressure: fill with i_ready low, then release
    begin
      int sent, got;
      logic hs, stable;
      logic [13:0] outs[4];
      int cyc[4];
      @(negedge i_clk);
      i_ready = 1'b0; sent = 0; stable = 1'b1;
      for (int c = 0; c < 6; c++) begin
        i_valid = (sent < 4);
        if (sent < 4) begin i_min = bp[sent].min; i_sub = bp[sent].sub; end
        #1;
        hs = i_valid && o_ready;
        if (o_valid && o_result !== bp[0].res) stable = 1'b0;
        @(posedge i_clk);
        if (hs) sent++;
        @(negedge i_clk);
      end
      i_valid = (sent < 4);
      if (sent < 4) begin i_min = bp[sent].min; i_sub = bp[sent].sub; end
      #1;
      chk("bp accepted", sent, 2);
      chk("bp o_ready full", o_ready, 0);
      chk("bp o_valid held", o_valid, 1);
      chk("bp result stable", stable, 1);
      i_ready = 1'b1; got = 0;
      #1;
      for (int c = 0; c < 20 && got < 4; c++) begin
        hs = i_valid && o_ready;
        if (o_valid) begin outs[got] = {o_err, o_result}; cyc[got] = c; got++; end
        @(posedge i_clk);
        if (hs) sent++;
        @(negedge i_clk);
        i_valid = (sent < 4);
        if (sent < 4) begin i_min = bp[sent].min; i_sub = bp[sent].sub; end
        #1;
      end
      i_valid = 1'b0;
      chk("bp drained", got, 4);
      for (int k = 0; k < 4; k++)
        chk($sformatf("bp out%0d", k), outs[k], {bp[k].err, bp[k].res});
      chk("bp consecutive", cyc[3] - cyc[0], 3);
    end

    // Random traffic against the reference model
    begin
      logic [13:0] exp_q[$];
      logic [13:0] hold_v, exp_v;
      logic hold, hs_in, hs_out;
      int nsent, nrecv, nbad;
      nsent = 0; nrecv = 0; nbad = 0; hold = 1'b0; hold_v = '0;
      for (int c = 0; c < 40000 && nrecv < 3000; c++) begin
        @(negedge i_clk);
        i_valid = (nsent < 3000) && ($urandom_range(0, 1) == 1);
        i_min = 14'($urandom);
        i_sub = 13'($urandom);
        i_ready = ($urandom_range(0, 1) == 1);
        #1;
        if (hold && {o_err, o_result} !== hold_v) nbad++;
        hs_in = i_valid && o_ready;
        hs_out = o_valid && i_ready;
        if (hs_in) begin exp_q.push_back(ref_fn(i_min, i_sub)); nsent++; end
        if (hs_out) begin
          if (exp_q.size() == 0) nbad++;
          else begin
            exp_v = exp_q.pop_front();
            if ({o_err, o_result} !== exp_v) nbad++;
          end
          nrecv++;
        end
        hold = o_valid && !i_ready;
        hold_v = {o_err, o_result};
      end
      i_valid = 1'b0;
      chk("rand mismatches", nbad, 0);
      chk("rand beats out", nrecv, 3000);
    end

    // Reset with two beats in flight
    begin
      int sent, seen;
      logic hs;
      @(negedge i_clk);
      i_ready = 1'b1; i_valid = 1'b0;
      repeat (4) @(negedge i_clk);
      i_ready = 1'b0; sent = 0;
      for (int c = 0; c < 10 && sent < 2; c++) begin
        i_valid = 1'b1; i_min = bp[sent].min; i_sub = bp[sent].sub;
        #1 hs = o_ready;
        @(posedge i_clk);
        if (hs) sent++;
        @(negedge i_clk);
      end
      i_valid = 1'b0;
      #1 chk("inflight o_valid", o_valid, 1);
      #2 i_rst = 1'b1;
      #1;
      chk("midrst o_valid", o_valid, 0);
      chk("midrst o_result", o_result, 0);
      chk("midrst o_err", o_err, 0);
      @(negedge i_clk);
      i_rst = 1'b0; i_ready = 1'b1; seen = 0;
      #1 chk("rel o_ready", o_ready, 1);
      for (int c = 0; c < 6; c++) begin
        @(negedge i_clk);
        #1 if (o_valid) seen++;
      end
      chk("no stale beat", seen, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
